key_expander: RTL

- Serves the controller's CHNGE_KEY state. Starts on change_key_start and collects a 128-bit AES key as four 32-bit words from the AHB rx path.
- Iteratively computes the 11 AES-128 round keys, one round per cycle, and stores them.
- Pulses chg_key_done back to the controller.
- The AES datapath reads stored round keys through an indexed, registered read port.

---
 rtl/aes_pkg.sv | 33 +++
 rtl/aes_sbox.sv | 29 ++
 rtl/key_expander.sv | 111 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-expander state encoding and GF(2^8) arithmetic.
// Used by the key expander and the cipher datapath.
package aes_pkg;

  localparam int AES_WORD_W  = 32;
  localparam int AES_BLOCK_W = 128;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EXPAND,
    DONE,
    WAIT_RELEASE
  } key_exp_state_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse (x^254) followed by the affine map.
// Zero latency; no flow control.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;

  always_comb begin
    // Addition chain to x^254; zero maps to zero as the S-box requires.
    x2   = gf_mul(byte_val, byte_val);
    x3   = gf_mul(x2, byte_val);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(x240, x14);
    sub_val = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/key_expander.sv
// AES-128 key schedule: loads four key words, expands one round per cycle into storage.
// Round keys are read back through a registered indexed port (1-cycle latency).
module key_expander
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   change_key_start,
  input  logic                   key_word_valid,
  input  logic [AES_WORD_W-1:0]  key_word,
  input  logic [3:0]             rd_round,
  output logic [AES_BLOCK_W-1:0] rd_key,
  output logic                   chg_key_done,
  output logic                   key_valid,
  output logic                   busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  key_exp_state_t state;
  logic [1:0] word_cnt;
  logic [3:0] round_cnt;
  logic [AES_BLOCK_W-1:0] key_mem [NUM_ROUNDS+1];

  logic [AES_BLOCK_W-1:0] prev_key;
  logic [AES_BLOCK_W-1:0] next_key;
  logic [AES_WORD_W-1:0]  rot_w3;
  logic [AES_WORD_W-1:0]  sub_w3;
  logic [AES_WORD_W-1:0]  nw0, nw1, nw2, nw3;

  assign prev_key = key_mem[round_cnt - 4'd1];
  assign rot_w3   = {prev_key[23:0], prev_key[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .byte_val (rot_w3[8*b +: 8]),
      .sub_val  (sub_w3[8*b +: 8])
    );
  end

  always_comb begin
    nw0 = prev_key[127:96] ^ sub_w3 ^ {RCON[round_cnt], 24'h000000};
    nw1 = prev_key[95:64] ^ nw0;
    nw2 = prev_key[63:32] ^ nw1;
    nw3 = prev_key[31:0] ^ nw2;
    next_key = {nw0, nw1, nw2, nw3};
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      word_cnt     <= 2'd0;
      round_cnt    <= 4'd0;
      rd_key       <= '0;
      chg_key_done <= 1'b0;
      key_valid    <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) key_mem[i] <= '0;
    end else begin
      chg_key_done <= 1'b0;
      rd_key       <= (rd_round <= LAST_ROUND) ? key_mem[rd_round] : '0;
      case (state)
        IDLE: begin
          if (change_key_start) begin
            state     <= LOAD;
            word_cnt  <= 2'd0;
            key_valid <= 1'b0;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (!change_key_start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (key_word_valid) begin
            // First word lands in the most significant slot of round key 0.
            key_mem[0][{2'd3 - word_cnt, 5'd0} +: AES_WORD_W] <= key_word;
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == 2'd3) begin
              state     <= EXPAND;
              round_cnt <= 4'd1;
            end
          end
        end
        EXPAND: begin
          if (!change_key_start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            key_mem[round_cnt] <= next_key;
            if (round_cnt == LAST_ROUND) state <= DONE;
            else round_cnt <= round_cnt + 4'd1;
          end
        end
        DONE: begin
          chg_key_done <= 1'b1;
          key_valid    <= 1'b1;
          busy         <= 1'b0;
          state        <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!change_key_start) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
